// File: rtl/eth_frame_tx_if.sv
// eth_frame_tx_if: header descriptor, payload stream and MAC TX FIFO stream
// of the Ethernet frame builder, bundled into one interface.
// slave  = the frame builder's view, master = the source/sink side.
interface eth_frame_tx_if;
  logic        s_hdr_valid;
  logic        s_hdr_ready;
  logic [47:0] s_hdr_dest_mac;
  logic [47:0] s_hdr_src_mac;
  logic [15:0] s_hdr_type;

  logic [7:0]  s_payload_axis_tdata;
  logic        s_payload_axis_tvalid;
  logic        s_payload_axis_tready;
  logic        s_payload_axis_tlast;
  logic        s_payload_axis_tuser;

  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;

  modport slave (
    input  s_hdr_valid, s_hdr_dest_mac, s_hdr_src_mac, s_hdr_type,
    output s_hdr_ready,
    input  s_payload_axis_tdata, s_payload_axis_tvalid,
           s_payload_axis_tlast, s_payload_axis_tuser,
    output s_payload_axis_tready,
    output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    input  m_axis_tready
  );

  modport master (
    output s_hdr_valid, s_hdr_dest_mac, s_hdr_src_mac, s_hdr_type,
    input  s_hdr_ready,
    output s_payload_axis_tdata, s_payload_axis_tvalid,
           s_payload_axis_tlast, s_payload_axis_tuser,
    input  s_payload_axis_tready,
    input  m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
    output m_axis_tready
  );
endinterface

// File: rtl/eth_frame_tx.sv
// eth_frame_tx: serialises a 14-byte Ethernet header followed by the payload
// stream into the MAC TX FIFO. Payloads reaching MAX_PAYLOAD without tlast
// are cut short and flagged bad (tuser) so the frame FIFO drops them; the
// rest of that payload is swallowed.
// Optional feature: define ETH_FRAME_TX_COUNT_EN to build the frame counter,
// otherwise frame_count is tied to zero.
module eth_frame_tx #(
  parameter int unsigned MAX_PAYLOAD = 1500
) (
  input  logic        logic_clk,
  input  logic        logic_rst_n,
  eth_frame_tx_if.slave bus,
  output logic        busy,
  output logic        status_oversize,
  output logic [15:0] frame_count
);

  typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, DRAIN} state_t;

  // Index of the payload byte that hits the size limit.
  localparam logic [16:0] LIMIT_IDX = 17'(MAX_PAYLOAD - 1);

  state_t       state;
  logic [111:0] hdr_sr;    // dest, src, type; top byte is next on the wire
  logic [3:0]   hdr_idx;
  logic [15:0]  pay_cnt;

  logic [7:0]   tdata_q;
  logic         tvalid_q;
  logic         tlast_q;
  logic         tuser_q;

  logic         load_en;
  logic         pay_fire;
  logic         at_limit;

  // Output register can take a new byte when empty or being consumed.
  assign load_en  = !tvalid_q || bus.m_axis_tready;
  assign pay_fire = (state == PAYLOAD) && bus.s_payload_axis_tvalid && load_en;
  assign at_limit = ({1'b0, pay_cnt} == LIMIT_IDX);

  assign bus.s_hdr_ready           = (state == IDLE) && load_en;
  assign bus.s_payload_axis_tready = ((state == PAYLOAD) && load_en) ||
                                     (state == DRAIN);

  assign bus.m_axis_tdata  = tdata_q;
  assign bus.m_axis_tvalid = tvalid_q;
  assign bus.m_axis_tlast  = tlast_q;
  assign bus.m_axis_tuser  = tuser_q;

  assign busy = (state != IDLE);

  // Frame FSM together with the single output register it feeds.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      state           <= IDLE;
      hdr_sr          <= '0;
      hdr_idx         <= '0;
      pay_cnt         <= '0;
      tdata_q         <= '0;
      tvalid_q        <= 1'b0;
      tlast_q         <= 1'b0;
      tuser_q         <= 1'b0;
      status_oversize <= 1'b0;
    end else begin
      status_oversize <= 1'b0;
      // Consumed byte leaves the register unless a new one is loaded below.
      if (tvalid_q && bus.m_axis_tready) tvalid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.s_hdr_valid && bus.s_hdr_ready) begin
            hdr_sr  <= {bus.s_hdr_dest_mac, bus.s_hdr_src_mac, bus.s_hdr_type};
            hdr_idx <= '0;
            state   <= HEADER;
          end
        end

        HEADER: begin
          if (load_en) begin
            tdata_q  <= hdr_sr[111:104];
            tvalid_q <= 1'b1;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            hdr_sr   <= {hdr_sr[103:0], 8'h00};
            hdr_idx  <= hdr_idx + 4'd1;
            if (hdr_idx == 4'd13) begin
              pay_cnt <= '0;
              state   <= PAYLOAD;
            end
          end
        end

        PAYLOAD: begin
          if (pay_fire) begin
            tdata_q  <= bus.s_payload_axis_tdata;
            tvalid_q <= 1'b1;
            pay_cnt  <= pay_cnt + 16'd1;
            // A real tlast wins over the limit: exactly MAX_PAYLOAD is good.
            if (bus.s_payload_axis_tlast) begin
              tlast_q <= 1'b1;
              tuser_q <= bus.s_payload_axis_tuser;
              state   <= IDLE;
            end else if (at_limit) begin
              tlast_q         <= 1'b1;
              tuser_q         <= 1'b1;
              status_oversize <= 1'b1;
              state           <= DRAIN;
            end else begin
              tlast_q <= 1'b0;
              tuser_q <= 1'b0;
            end
          end
        end

        DRAIN: begin
          if (bus.s_payload_axis_tvalid && bus.s_payload_axis_tlast) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef ETH_FRAME_TX_COUNT_EN
  logic last_load;

  // A frame counts when its closing byte enters the output register.
  assign last_load = pay_fire && (bus.s_payload_axis_tlast || at_limit);

  // Completed-frame counter, wraps naturally at 16 bits.
  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n)   frame_count <= '0;
    else if (last_load) frame_count <= frame_count + 16'd1;
  end
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_eth_frame_tx.sv
// tb_eth_frame_tx: directed frames against a queue model of the expected
// output byte stream; one negedge process checks every transferred beat and
// byte stability under backpressure.
module tb_eth_frame_tx;
  localparam int MP = 48;
  typedef logic [9:0] beat_t;  // {data, last, user}

  localparam logic [47:0] D1 = 48'h020000000001;
  localparam logic [47:0] S1 = 48'h020000000002;
  localparam logic [47:0] D2 = 48'h112233445566;
  localparam logic [47:0] S2 = 48'h778899AABBCC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, osz;
  logic [15:0] fcnt;

  eth_frame_tx_if bif();

  eth_frame_tx #(.MAX_PAYLOAD(MP)) dut (
    .logic_clk       (clk),
    .logic_rst_n     (rst_n),
    .bus             (bif.slave),
    .busy            (busy),
    .status_oversize (osz),
    .frame_count     (fcnt)
  );

  always #5 clk = ~clk;

  int    vectors = 0, errs = 0;
  beat_t exp_q[$];
  int    exp_frames = 0, exp_osz = 0, osz_seen = 0;
  int    cyc = 0, fb = 0, first_cyc = 0, last_cyc = 0;
  bit    rnd_mode = 1'b0;
  bit    hdr_coincide = 1'b0;
  bit    stall_v = 1'b0;
  beat_t stall_word = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int fc_exp();
`ifdef ETH_FRAME_TX_COUNT_EN
    return exp_frames & 32'hFFFF;
`else
    return 0;
`endif
  endfunction

  // Expected wire image of one frame: header bytes MSB first, then the
  // payload clipped at MP bytes, clipped frames marked bad.
  task automatic model_frame(input logic [47:0] d, input logic [47:0] s,
                             input logic [15:0] t, input int len,
                             input logic [7:0] base, input logic user);
    logic [111:0] h;
    int n;
    logic lst, usr;
    h = {d, s, t};
    for (int i = 0; i < 14; i++) exp_q.push_back({h[111-8*i -: 8], 2'b00});
    n = (len > MP) ? MP : len;
    for (int i = 0; i < n; i++) begin
      lst = (i == n - 1);
      usr = lst ? ((len > MP) ? 1'b1 : user) : 1'b0;
      exp_q.push_back({8'(base + i), lst, usr});
    end
    if (len > MP) exp_osz++;
    exp_frames++;
  endtask

  // Tasks start and end just after a rising edge; handshakes are sampled
  // at the falling edge before the accepting rising edge.
  task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    int n;
    n = 0;
    bif.s_hdr_dest_mac = d;
    bif.s_hdr_src_mac  = s;
    bif.s_hdr_type     = t;
    bif.s_hdr_valid    = 1'b1;
    forever begin
      @(negedge clk);
      if (bif.s_hdr_ready) break;
      if (++n > 200) begin chk("hdr_timeout", 32'd1, 32'd0); break; end
    end
    hdr_coincide = bif.m_axis_tvalid && bif.m_axis_tlast && bif.m_axis_tready;
    @(posedge clk); #1;
    bif.s_hdr_valid = 1'b0;
  endtask

  task automatic send_payload(input int len, input logic [7:0] base, input logic user);
    int n;
    for (int i = 0; i < len; i++) begin
      bif.s_payload_axis_tdata  = 8'(base + i);
      bif.s_payload_axis_tvalid = 1'b1;
      bif.s_payload_axis_tlast  = (i == len - 1);
      bif.s_payload_axis_tuser  = (i == len - 1) ? user : 1'b0;
      n = 0;
      forever begin
        @(negedge clk);
        if (bif.s_payload_axis_tready) break;
        if (++n > 200) begin chk("pay_timeout", 32'(i), 32'(len)); break; end
      end
      @(posedge clk); #1;
    end
    bif.s_payload_axis_tvalid = 1'b0;
    bif.s_payload_axis_tlast  = 1'b0;
    bif.s_payload_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Sink backpressure.
  initial begin
    bif.m_axis_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bif.m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Compare process: every transferred beat against the model queue,
  // stalled bytes must not change.
  initial forever begin
    beat_t b;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      stall_v = 1'b0;
      fb = 0;
    end else begin
      if (stall_v)
        chk("hold", 32'({bif.m_axis_tvalid, bif.m_axis_tdata, bif.m_axis_tlast, bif.m_axis_tuser}),
            32'({1'b1, stall_word}));
      if (osz) osz_seen++;
      if (bif.m_axis_tvalid && bif.m_axis_tready) begin
        if (exp_q.size() == 0) chk("extra_beat", 32'd1, 32'd0);
        else begin
          b = exp_q.pop_front();
          chk("beat", 32'({bif.m_axis_tdata, bif.m_axis_tlast, bif.m_axis_tuser}), 32'(b));
        end
        if (fb == 0) first_cyc = cyc;
        fb++;
        if (bif.m_axis_tlast) begin last_cyc = cyc; fb = 0; end
      end
      stall_v    = bif.m_axis_tvalid && !bif.m_axis_tready;
      stall_word = {bif.m_axis_tdata, bif.m_axis_tlast, bif.m_axis_tuser};
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tvalid"}, 32'(bif.m_axis_tvalid), 32'd0);
    chk({tag, "_tdata"},  32'(bif.m_axis_tdata),  32'd0);
    chk({tag, "_tlast"},  32'(bif.m_axis_tlast),  32'd0);
    chk({tag, "_tuser"},  32'(bif.m_axis_tuser),  32'd0);
    chk({tag, "_busy"},   32'(busy),              32'd0);
    chk({tag, "_osz"},    32'(osz),               32'd0);
    chk({tag, "_fcnt"},   32'(fcnt),              32'd0);
    chk({tag, "_ptready"}, 32'(bif.s_payload_axis_tready), 32'd0);
  endtask

  initial begin
    int n;
    bif.s_hdr_valid = 1'b0;
    bif.s_hdr_dest_mac = '0;
    bif.s_hdr_src_mac = '0;
    bif.s_hdr_type = '0;
    bif.s_payload_axis_tdata = '0;
    bif.s_payload_axis_tvalid = 1'b0;
    bif.s_payload_axis_tlast = 1'b0;
    bif.s_payload_axis_tuser = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("hdr_ready_rel", 32'(bif.s_hdr_ready), 32'd1);
    @(posedge clk); #1;

    // Basic 46-byte IPv4 frame, sink always ready.
    model_frame(D1, S1, 16'h0800, 46, 8'h00, 1'b0);
    chk("model_len", 32'(exp_q.size()), 32'd60);
    chk("model_b0",  32'(exp_q[0]),  32'({8'h02, 2'b00}));
    chk("model_b59", 32'(exp_q[59]), 32'({8'h2D, 2'b10}));
    send_hdr(D1, S1, 16'h0800);
    @(negedge clk);
    chk("lat_early", 32'(bif.m_axis_tvalid), 32'd0);
    @(negedge clk);
    chk("lat_first", 32'({bif.m_axis_tvalid, bif.m_axis_tdata}), 32'({1'b1, 8'h02}));
    @(posedge clk); #1;
    send_payload(46, 8'h00, 1'b0);
    wait_drain();
    chk("span60", 32'(last_cyc - first_cyc + 1), 32'd60);
    chk("fcnt1", 32'(fcnt), 32'(fc_exp()));
    chk("busy_idle", 32'(busy), 32'd0);

    // Same frame under random backpressure.
    rnd_mode = 1'b1;
    model_frame(D1, S1, 16'h0800, 46, 8'h00, 1'b0);
    send_hdr(D1, S1, 16'h0800);
    send_payload(46, 8'h00, 1'b0);
    wait_drain();
    rnd_mode = 1'b0;
    @(posedge clk); #1;
    chk("fcnt2", 32'(fcnt), 32'(fc_exp()));

    // Exactly MP bytes with tlast: good frame, no oversize.
    model_frame(D1, S1, 16'h86DD, MP, 8'h40, 1'b0);
    send_hdr(D1, S1, 16'h86DD);
    send_payload(MP, 8'h40, 1'b0);
    wait_drain();
    chk("osz_exact", 32'(osz_seen), 32'(exp_osz));

    // Oversize: MP+4 bytes, clipped at byte MP-1, remainder discarded.
    model_frame(D1, S1, 16'h0800, MP + 4, 8'h00, 1'b0);
    chk("model_osz_len",  32'(exp_q.size()), 32'd62);
    chk("model_osz_last", 32'(exp_q[61]), 32'({8'h2F, 2'b11}));
    send_hdr(D1, S1, 16'h0800);
    send_payload(MP + 4, 8'h00, 1'b0);
    @(negedge clk);
    chk("busy_after_drain", 32'(busy), 32'd0);
    @(posedge clk); #1;
    wait_drain();
    chk("osz_once", 32'(osz_seen), 32'd1);
    chk("fcnt4", 32'(fcnt), 32'(fc_exp()));

    // Bad-frame flag passthrough, next header overlaps the last byte drain.
    model_frame(D2, S2, 16'h0806, 5, 8'h80, 1'b1);
    model_frame(D1, S2, 16'h0800, 3, 8'h90, 1'b0);
    send_hdr(D2, S2, 16'h0806);
    send_payload(5, 8'h80, 1'b1);
    send_hdr(D1, S2, 16'h0800);
    chk("hdr_overlap", 32'(hdr_coincide), 32'd1);
    send_payload(3, 8'h90, 1'b0);
    wait_drain();
    chk("fcnt6", 32'(fcnt), 32'(fc_exp()));

    // Asynchronous reset in the middle of the header (byte 7 = src[39:32]).
    model_frame(D2, S2, 16'h88B5, 10, 8'h00, 1'b0);
    send_hdr(D2, S2, 16'h88B5);
    n = 0;
    forever begin
      @(negedge clk);
      if (bif.m_axis_tvalid && bif.m_axis_tdata == 8'h88) break;
      if (++n > 50) begin chk("byte7_timeout", 32'd1, 32'd0); break; end
    end
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    exp_q.delete();
    exp_frames = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("hdr_ready_rel2", 32'(bif.s_hdr_ready), 32'd1);
    @(posedge clk); #1;
    model_frame(D1, S1, 16'h0800, 46, 8'h10, 1'b0);
    send_hdr(D1, S1, 16'h0800);
    send_payload(46, 8'h10, 1'b0);
    wait_drain();
    chk("fcnt_post_rst", 32'(fcnt), 32'(fc_exp()));
    chk("busy_end", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // Global time bound.
  initial begin
    #500000;
    errs++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/eth_frame_tx.md
# eth_frame_tx

Ethernet frame builder on the logic-clock side of the 1G RGMII MAC. It accepts a header descriptor and an 8-bit AXI-stream payload. It serialises the 14-byte Ethernet header followed by the payload onto the MAC TX FIFO input (`tx_axis_*`). It is the transmit-side counterpart of the RX path's frame stream: it produces what the MAC transmit path consumes, and it enforces a payload size limit by marking oversize frames bad so that the frame FIFO drops them.

## Interface
Parameters:
- `MAX_PAYLOAD`, 1500: maximum payload bytes per frame; 1..65535.

Ports:
- `logic_clk`  in  1  sole clock.
- `logic_rst_n`  in  1  asynchronous active-low reset.
- `s_hdr_valid`  in  1  header descriptor valid.
- `s_hdr_ready`  out  1  header descriptor accepted.
- `s_hdr_dest_mac`  in  48  destination MAC; bits [47:40] are sent first.
- `s_hdr_src_mac`  in  48  source MAC; bits [47:40] are sent first.
- `s_hdr_type`  in  16  EtherType; bits [15:8] are sent first.
- `s_payload_axis_tdata`  in  8  payload byte.
- `s_payload_axis_tvalid`  in  1  payload valid.
- `s_payload_axis_tready`  out  1  payload ready.
- `s_payload_axis_tlast`  in  1  last payload byte.
- `s_payload_axis_tuser`  in  1  bad-frame flag; sampled on the tlast beat.
- `m_axis_tdata`  out  8  frame byte to the MAC TX FIFO.
- `m_axis_tvalid`  out  1  frame byte valid.
- `m_axis_tready`  in  1  MAC TX FIFO ready.
- `m_axis_tlast`  out  1  last frame byte.
- `m_axis_tuser`  out  1  bad frame; the FIFO drops the frame.
- `busy`  out  1  high in every state except IDLE.
- `status_oversize`  out  1  one-cycle pulse when a frame is truncated.
- `frame_count`  out  16  count of completed frames (see Configuration).

## Operation
- FSM states: IDLE, HEADER, PAYLOAD, DRAIN.
- IDLE:
  - `s_hdr_ready`=1 when the output register is empty or being consumed.
  - On `s_hdr_valid`, latch the three header fields, clear the byte index, and go to HEADER.
- HEADER:
  - Emit the 14 bytes in this order: dest[47:40]..dest[7:0], src[47:40]..src[7:0], type[15:8], type[7:0].
  - The 4-bit index advances on each output load.
  - After byte 13 is loaded, go to PAYLOAD.
  - The header never asserts tlast or tuser.
- PAYLOAD:
  - `s_payload_axis_tready` = !`m_axis_tvalid` || `m_axis_tready`.
  - Each accepted byte is loaded into the output register with its tlast and tuser.
  - A 16-bit payload counter increments per accepted byte.
  - Input tlast: load the byte with tlast=1 and tuser = input tuser, then go to IDLE.
  - Oversize: the byte that brings the count to `MAX_PAYLOAD` arrives without tlast. Load it with tlast=1 and tuser=1, pulse `status_oversize`, and go to DRAIN.
- DRAIN:
  - `s_payload_axis_tready`=1; bytes are discarded and nothing is output.
  - Input tlast returns the FSM to IDLE.
- Single output register: it loads when !`m_axis_tvalid` || `m_axis_tready`. tdata, tlast and tuser hold stable while tvalid=1 and tready=0.
- Simultaneous events: the IDLE header accept can coincide with the output register draining the previous tlast byte. No idle cycle is required between frames.
- A payload of exactly `MAX_PAYLOAD` bytes with tlast on the final byte is a good frame; it is not treated as oversize.
- An empty payload cannot be expressed. The MAC pads short frames.

## Timing
- Header is accepted on edge N; `m_axis_tvalid`=1 with dest[47:40] after edge N+1.
- With `m_axis_tready` held at 1:
  - The header takes 14 consecutive cycles.
  - The first payload byte appears on the cycle after header byte 13, provided the payload is valid.
  - Throughput is 1 byte/cycle.
- `s_payload_axis_tready` is combinational from `m_axis_tready` and the state. `s_hdr_ready` is combinational from the state and the output register.
- Async reset: assertion takes immediate effect, including mid-frame.
  - FSM → IDLE, counters cleared.
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0, `m_axis_tuser`=0.
  - `busy`=0, `status_oversize`=0, `frame_count`=0.
  - `s_payload_axis_tready`=0.
  - `s_hdr_ready`=1 after reset release.
- A partially sent frame is abandoned without tlast. The TX FIFO is reset by the same reset tree.

## Configuration
- `ETH_FRAME_TX_COUNT_EN` defined:
  - `frame_count` increments (wrapping 0xFFFF→0) on the cycle a tlast byte is loaded into the output register. Oversize frames count.
- Undefined:
  - `frame_count` is tied to 0 and no counter logic is built.

## Test plan
- Header dest=02:00:00:00:00:01, src=02:00:00:00:00:02, type=0x0800, 46-byte payload 0x00..0x2D, tready=1 → 60 beats: 14 header bytes in order, then the payload; tlast only on beat 60 (0x2D), tuser=0; `frame_count`=1.
- Same frame with `m_axis_tready` toggled by a pseudo-random pattern (50%) → identical byte sequence, no byte loss or duplication, data held stable while stalled.
- `MAX_PAYLOAD`=16, 20-byte payload → 30 output beats; beat 30 (payload byte 15) has tlast=1 and tuser=1; `status_oversize` pulses once; payload bytes 16..19 are accepted and discarded; `busy` falls after input tlast.
- Payload tlast beat with tuser=1 → the last output byte has tuser=1; the next header is accepted on the same cycle the last byte drains.
- `logic_rst_n` asserted at header byte 7 → all outputs at reset values asynchronously; after release, a new frame is sent cleanly starting from dest[47:40].
